// File: rtl/gbprocessor_pkg.sv
// Shared encodings and constants for the gbprocessor ALU datapath.
package gbprocessor_pkg;

  typedef enum logic [2:0] {ADD, ADC, SUB, SBC, AND, XOR, OR, CP} alu_op_t;
  typedef enum logic [2:0] {B, C, D, E, H, L, HL, A} reg_sel_t;

  localparam int unsigned FLAG_Z = 7;
  localparam int unsigned FLAG_N = 6;
  localparam int unsigned FLAG_H = 5;
  localparam int unsigned FLAG_C = 4;

  localparam logic [7:0] CPL = 8'h2F;
  localparam logic [7:0] SCF = 8'h37;
  localparam logic [7:0] CCF = 8'h3F;

  localparam logic [7:0] RST_A = 8'h01;
  localparam logic [7:0] RST_F = 8'hB0;
  localparam logic [7:0] RST_B = 8'h00;
  localparam logic [7:0] RST_C = 8'h13;
  localparam logic [7:0] RST_D = 8'h00;
  localparam logic [7:0] RST_E = 8'hD8;
  localparam logic [7:0] RST_H = 8'h01;
  localparam logic [7:0] RST_L = 8'h4D;

endpackage

// File: rtl/gbprocessor_iface.sv
// Bundles the gbprocessor stimulus and probe signals for a bench.
interface gbprocessor_iface (input logic clock);
  logic        reset;
  logic [7:0]  instruction;
  logic        valid;
  logic [15:0] probe;
endinterface

// File: rtl/gbprocessor_alu.sv
// Combinational 8-bit ALU: result plus Z/N/H/C for the eight register-to-A ops.
module gbprocessor_alu
  import gbprocessor_pkg::*;
(
  input  alu_op_t    op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] s_i,
  input  logic       cin_i,
  output logic [7:0] res_o,
  output logic       z_o,
  output logic       n_o,
  output logic       h_o,
  output logic       c_o
);

  logic       carry;
  logic [8:0] sum9;
  logic [4:0] hsum5;
  logic [8:0] dif9;
  logic [4:0] hdif5;

  always_comb begin
    carry = ((op_i == ADC) || (op_i == SBC)) ? cin_i : 1'b0;
    sum9  = {1'b0, a_i} + {1'b0, s_i} + {8'b0, carry};
    hsum5 = {1'b0, a_i[3:0]} + {1'b0, s_i[3:0]} + {4'b0, carry};
    // Bit 8 / bit 4 of the widened difference is the borrow out.
    dif9  = {1'b0, a_i} - {1'b0, s_i} - {8'b0, carry};
    hdif5 = {1'b0, a_i[3:0]} - {1'b0, s_i[3:0]} - {4'b0, carry};

    res_o = '0;
    n_o   = 1'b0;
    h_o   = 1'b0;
    c_o   = 1'b0;
    case (op_i)
      ADD, ADC: begin
        res_o = sum9[7:0];
        h_o   = hsum5[4];
        c_o   = sum9[8];
      end
      SUB, SBC, CP: begin
        res_o = dif9[7:0];
        n_o   = 1'b1;
        h_o   = hdif5[4];
        c_o   = dif9[8];
      end
      AND: begin
        res_o = a_i & s_i;
        h_o   = 1'b1;
      end
      XOR: res_o = a_i ^ s_i;
      OR:  res_o = a_i | s_i;
      default: ;
    endcase
    z_o = (res_o == 8'h00);
  end

endmodule

// File: rtl/gbprocessor.sv
// SM83-style single-cycle ALU datapath: register file, decode and flag write-back.
module gbprocessor
  import gbprocessor_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  instruction,
  input  logic        valid,
  output logic [15:0] probe
);

  logic [7:0] a_q, a_d, f_q, f_d;
  logic [7:0] b_q, c_q, d_q, e_q, h_q, l_q;
  logic [7:0] src;
  logic [7:0] alu_res;
  logic       alu_z, alu_n, alu_h, alu_c;
  alu_op_t    op;

  assign op = alu_op_t'(instruction[5:3]);

  always_comb begin
    src = '0;
    case (reg_sel_t'(instruction[2:0]))
      B:       src = b_q;
      C:       src = c_q;
      D:       src = d_q;
      E:       src = e_q;
      H:       src = h_q;
      L:       src = l_q;
      A:       src = a_q;
      default: src = '0;
    endcase
  end

  gbprocessor_alu u_alu (
    .op_i  (op),
    .a_i   (a_q),
    .s_i   (src),
    .cin_i (f_q[FLAG_C]),
    .res_o (alu_res),
    .z_o   (alu_z),
    .n_o   (alu_n),
    .h_o   (alu_h),
    .c_o   (alu_c)
  );

  always_comb begin
    a_d = a_q;
    f_d = f_q;
    if (valid) begin
      case (instruction[7:6])
        2'b10: begin
          // (HL) has no memory behind it, so the whole op is dropped.
          if (reg_sel_t'(instruction[2:0]) != HL) begin
            if (op != CP) a_d = alu_res;
            f_d = {alu_z, alu_n, alu_h, alu_c, 4'b0000};
          end
        end
        2'b00: begin
          case (instruction)
            CPL: begin
              a_d = ~a_q;
              f_d = {f_q[FLAG_Z], 1'b1, 1'b1, f_q[FLAG_C], 4'b0000};
            end
            SCF: f_d = {f_q[FLAG_Z], 1'b0, 1'b0, 1'b1, 4'b0000};
            CCF: f_d = {f_q[FLAG_Z], 1'b0, 1'b0, ~f_q[FLAG_C], 4'b0000};
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      a_q <= RST_A;
      f_q <= RST_F;
      b_q <= RST_B;
      c_q <= RST_C;
      d_q <= RST_D;
      e_q <= RST_E;
      h_q <= RST_H;
      l_q <= RST_L;
    end else begin
      a_q <= a_d;
      f_q <= f_d;
    end
  end

  assign probe = {a_q, f_q};

endmodule

// File: tb/tb_gbprocessor.sv
// Self-checking bench for gbprocessor: directed vector table plus random/sweep vs a model.
module tb_gbprocessor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  gbprocessor_iface ifc (.clock(clk));

  gbprocessor dut (
    .clock       (clk),
    .reset       (ifc.reset),
    .instruction (ifc.instruction),
    .valid       (ifc.valid),
    .probe       (ifc.probe)
  );

  int nvec = 0;
  int nmis = 0;

  // Reference state: plain integers and flag bits.
  int m_a;
  bit mz, mn, mh, mc;
  int m_regs[6] = '{8'h00, 8'h13, 8'h00, 8'hD8, 8'h01, 8'h4D};

  function automatic logic [15:0] m_probe();
    logic [7:0] a8;
    a8 = m_a[7:0];
    return {a8, mz, mn, mh, mc, 4'b0000};
  endfunction

  task automatic m_reset();
    m_a = 1; mz = 1; mn = 0; mh = 1; mc = 1;
  endtask

  task automatic m_exec(input logic [7:0] ins, input bit vld);
    int ii, op, sel, s, cin, r;
    if (!vld) return;
    ii = int'(ins);
    if (ii >= 'h80 && ii <= 'hBF && (ii % 8) != 6) begin
      op  = (ii / 8) % 8;
      sel = ii % 8;
      s   = (sel == 7) ? m_a : m_regs[sel];
      cin = (op == 1 || op == 3) ? int'(mc) : 0;
      case (op)
        0, 1: begin
          r  = m_a + s + cin;
          mh = ((m_a % 16) + (s % 16) + cin) > 15;
          mc = r > 255;
          mn = 0;
          r  = r % 256;
          m_a = r;
        end
        2, 3, 7: begin
          mh = (m_a % 16) < ((s % 16) + cin);
          mc = m_a < (s + cin);
          mn = 1;
          r  = (m_a - s - cin + 512) % 256;
          if (op != 7) m_a = r;
        end
        4: begin r = m_a & s; mn = 0; mh = 1; mc = 0; m_a = r; end
        5: begin r = m_a ^ s; mn = 0; mh = 0; mc = 0; m_a = r; end
        default: begin r = m_a | s; mn = 0; mh = 0; mc = 0; m_a = r; end
      endcase
      mz = (r == 0);
    end else if (ii == 'h2F) begin
      m_a = 255 - m_a; mn = 1; mh = 1;
    end else if (ii == 'h37) begin
      mn = 0; mh = 0; mc = 1;
    end else if (ii == 'h3F) begin
      mn = 0; mh = 0; mc = ~mc;
    end
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    nvec++;
    if (ifc.probe !== exp) begin
      nmis++;
      $display("FAIL %s: probe=%04h expected=%04h", name, ifc.probe, exp);
    end
  endtask

  // Present inputs, let one rising edge pass, then sample 1 time unit later.
  task automatic step(input bit rst_n, input logic [7:0] ins, input bit vld);
    ifc.reset = rst_n;
    ifc.instruction = ins;
    ifc.valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    m_reset();
  endtask

  typedef struct {
    bit         rst_before;
    logic [7:0] ins;
    bit         vld;
    logic [15:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1, 8'h81, 1, 16'h1400, "add_a_c"});
    vecs.push_back('{1, 8'h88, 1, 16'h0200, "adc_a_b"});
    vecs.push_back('{1, 8'h97, 1, 16'h00C0, "sub_a_a"});
    vecs.push_back('{0, 8'h2F, 1, 16'hFFE0, "cpl"});
    vecs.push_back('{0, 8'h3F, 1, 16'hFF90, "ccf"});
    vecs.push_back('{1, 8'hB8, 1, 16'h0140, "cp_b"});
    vecs.push_back('{0, 8'h86, 1, 16'h0140, "add_hl_nop"});
    vecs.push_back('{0, 8'h00, 1, 16'h0140, "nop00"});
    vecs.push_back('{0, 8'h97, 0, 16'h0140, "valid_low"});
    vecs.push_back('{0, 8'h37, 1, 16'h0110, "scf"});
    vecs.push_back('{0, 8'hxx, 1, 16'h0110, "x_instr"});
    vecs.push_back('{1, 8'hA0, 1, 16'h00A0, "and_b"});
    vecs.push_back('{1, 8'hAF, 1, 16'h0080, "xor_a"});
    vecs.push_back('{1, 8'hB1, 1, 16'h1300, "or_c"});
    vecs.push_back('{1, 8'h9B, 1, 16'h2870, "sbc_e"});
    vecs.push_back('{1, 8'h83, 1, 16'hD900, "add_e"});

    ifc.reset = 1'b0;
    ifc.instruction = 8'h00;
    ifc.valid = 1'b0;

    do_reset();
    check("reset", 16'h01B0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h80, 1'b0);
      check("reset_hold", 16'h01B0);
    end

    foreach (vecs[k]) begin
      if (vecs[k].rst_before) do_reset();
      step(1'b1, vecs[k].ins, vecs[k].vld);
      check(vecs[k].name, vecs[k].exp);
    end

    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ins;
      ins = 8'(i);
      step(1'b1, ins, 1'b1);
      m_exec(ins, 1'b1);
      check("sweep", m_probe());
    end

    for (int i = 0; i < 600; i++) begin
      logic [7:0] ins;
      bit vld, rst_n;
      ins   = 8'($urandom_range(0, 255));
      vld   = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 39) != 0);
      step(rst_n, ins, vld);
      if (!rst_n) m_reset();
      else m_exec(ins, vld);
      check("random", m_probe());
    end

    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ins;
      ins = 8'(8'h80 + i * 9);
      step(1'b1, ins, 1'b1);
      m_exec(ins, 1'b1);
      check("midsweep", m_probe());
    end
    step(1'b0, 8'h87, 1'b1);
    m_reset();
    check("midsweep_reset", 16'h01B0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
